sb_lsu: RTL

- Load/store unit that sits directly upstream of the system-bus peripheral controllers, LED controller included.
- Takes one load/store request from the core and issues one word-aligned bus transaction with byte enables.
- Holds the core in stall until the transaction completes, then returns sign- or zero-extended load data.
- Flags misaligned, illegal-size and timed-out accesses instead of hanging the core.

---
 rtl/sb_lsu_pkg.sv | 21 ++
 rtl/sb_lsu_if.sv | 25 ++
 rtl/sb_lsu_align.sv | 50 +++++
 rtl/sb_lsu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sb_lsu_pkg.sv
// Shared size codes, FSM state and error codes for the system-bus load/store unit.
package sb_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLSIZE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sb_lsu_if.sv
// System-bus side of the load/store unit, plus a debug view of the LSU state.
// Handshake: mem_req_o holds with stable we/be/addr/wd until a cycle where mem_ready_i=1 completes it.
interface sb_lsu_if;
  import sb_lsu_pkg::*;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  state_t      dbg_state;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, dbg_state,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, dbg_state,
    output mem_rd_i, mem_ready_i
  );

endinterface

// File: rtl/sb_lsu_align.sv
// Lane logic: byte enables, store-data replication, load extraction and access legality.
module sb_lsu_align
  import sb_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] rd_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rd_i[{addr_i, 3'b000} +: 8];
  assign rd_half = addr_i[1] ? rd_i[31:16] : rd_i[15:0];

  always_comb begin
    be_o       = 4'b0000;
    wd_o       = 32'h0;
    rd_o       = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (size_i)
      LDST_B, LDST_BU: begin
        be_o = 4'b0001 << addr_i;
        wd_o = {4{wd_i[7:0]}};
        rd_o = {{24{rd_byte[7] & (size_i == LDST_B)}}, rd_byte};
      end
      LDST_H, LDST_HU: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wd_o       = {2{wd_i[15:0]}};
        rd_o       = {{16{rd_half[15] & (size_i == LDST_H)}}, rd_half};
        misalign_o = addr_i[0];
      end
      LDST_W: begin
        be_o       = 4'b1111;
        wd_o       = wd_i;
        rd_o       = rd_i;
        misalign_o = (addr_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/sb_lsu.sv
// Load/store unit: latches one core request, runs one bus transaction, returns data or an error.
module sb_lsu
  import sb_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  sb_lsu_if.master    bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [2:0]  sel_size;
  logic [1:0]  sel_addr;
  logic [31:0] sel_wd;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] lane_rd;
  logic        misalign;
  logic        illegal;
  logic        in_bus;

  // In IDLE the legality check must see the live request; afterwards only latched values matter.
  assign sel_size = (state_q == IDLE) ? core_size_i      : size_q;
  assign sel_addr = (state_q == IDLE) ? core_addr_i[1:0] : addr_q[1:0];
  assign sel_wd   = (state_q == IDLE) ? core_wd_i        : wd_q;

  sb_lsu_align u_align (
    .size_i     (sel_size),
    .addr_i     (sel_addr),
    .wd_i       (sel_wd),
    .rd_i       (bus.mem_rd_i),
    .be_o       (lane_be),
    .wd_o       (lane_wd),
    .rd_o       (lane_rd),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 32'h0;
      wd_q       <= 32'h0;
      cnt_q      <= 8'd0;
      rd_q       <= 32'h0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          we_d   = core_we_i;
          size_d = core_size_i;
          addr_d = core_addr_i;
          wd_d   = core_wd_i;
          cnt_d  = 8'd0;
          if (illegal) begin
            state_d    = DONE;
            err_d      = 1'b1;
            err_code_d = ERR_ILLSIZE;
          end else if (misalign) begin
            state_d    = DONE;
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mem_ready_i) begin
          if (!we_q) rd_d = lane_rd;
          state_d    = DONE;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end else if (cnt_q == CNT_LAST) begin
          rd_d       = 32'h0;
          state_d    = DONE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      DONE: begin
        state_d    = IDLE;
        cnt_d      = 8'd0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_bus         = (state_q == BUS);
  assign bus.mem_req_o  = in_bus;
  assign bus.mem_we_o   = in_bus & we_q;
  assign bus.mem_be_o   = in_bus ? lane_be : 4'b0000;
  assign bus.mem_addr_o = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wd_o   = in_bus ? lane_wd : 32'h0;
  assign bus.dbg_state  = state_q;

  assign core_rd_o    = rd_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign core_stall_o = core_req_i & (state_q != DONE);

endmodule
